ber_checker: RTL and testbench

- Parametrised receive-side BER checker.
- Decimates the filter output stream by OS at a selectable phase and slices BPSK symbols to bits.
- Searches the channel latency against a local PRBS9 reference, locks, then counts bits and errors with loss-of-lock detection.
- Sits after filtro_fir in the top; replaces the fixed rx_buffer/offset logic and drives the BER LED.

---
 rtl/ber_checker_pkg.sv | 21 ++
 rtl/ber_checker_prbs9.sv | 25 ++
 rtl/ber_checker.sv | 183 ++++++++++++++++++
 tb/tb_ber_checker.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ber_checker_pkg.sv
// Shared definitions for the BER checker: FSM encodings, PRBS9 polynomial
// constants and a width helper.
package ber_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int PRBS9_ORDER = 9;
  localparam int PRBS9_LEN   = 511;
  localparam int PRBS9_TAP_A = 9;
  localparam int PRBS9_TAP_B = 5;

  // Width helper that never returns zero, so a 1-entry range still gets a port bit.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/ber_checker_prbs9.sv
// PRBS9 generator (x^9 + x^5 + 1), MSB-out, advancing one step per i_enable.
module ber_checker_prbs9
  import ber_checker_pkg::*;
#(
  parameter logic [PRBS9_ORDER-1:0] SEED = 9'h1AA
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_bit
);

  logic [PRBS9_ORDER-1:0] r_sr;

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_sr <= SEED;
    end else if (i_enable) begin
      r_sr <= {r_sr[PRBS9_ORDER-2:0], r_sr[PRBS9_TAP_A-1] ^ r_sr[PRBS9_TAP_B-1]};
    end
  end

  assign o_bit = r_sr[PRBS9_ORDER-1];

endmodule

// File: rtl/ber_checker.sv
// Receive-side BER checker: decimate, slice, search latency against PRBS9, lock and count.
// Optional BER_AUTOPHASE_EN steps the sampling phase after each failed full latency sweep.
module ber_checker
  import ber_checker_pkg::*;
#(
  parameter int                     NB_DATA  = 8,
  parameter int                     OS       = 4,
  parameter logic [PRBS9_ORDER-1:0] SEED     = 9'h1AA,
  parameter int                     MAX_LAT  = 511,
  parameter int                     NB_WIN   = 6,
  parameter int                     LOCK_THR = 0,
  parameter int                     LOL_THR  = 8,
  parameter int                     NB_COUNT = 64
) (
  input  logic                            clock,
  input  logic                            i_reset,
  input  logic [NB_DATA-1:0]              i_data,
  input  logic                            i_valid,
  input  logic                            i_enable,
  input  logic [clog2_min1(OS)-1:0]       i_phase,
  input  logic                            i_clear,
  output logic                            o_lock,
  output logic [clog2_min1(MAX_LAT)-1:0]  o_latency,
  output logic [clog2_min1(OS)-1:0]       o_phase,
  output logic [NB_COUNT-1:0]             o_bit_count,
  output logic [NB_COUNT-1:0]             o_error_count,
  output logic                            o_ber_zero
);

  localparam int NB_PHASE = clog2_min1(OS);
  localparam int NB_LAT   = clog2_min1(MAX_LAT);
  localparam logic [NB_PHASE-1:0] PHASE_MAX = NB_PHASE'(OS - 1);
  localparam logic [NB_LAT-1:0]   LAT_MAX   = NB_LAT'(MAX_LAT - 1);

  state_t                r_state, w_state_n;
  logic [NB_LAT-1:0]     r_latency, w_lat_n;
  logic [NB_PHASE-1:0]   r_phase, w_phase_n;
  logic [NB_PHASE-1:0]   r_phase_cnt;
  logic [NB_WIN-1:0]     r_win_cnt, w_win_cnt_n;
  logic [NB_WIN:0]       r_win_err, w_win_err_n;
  logic [NB_COUNT-1:0]   r_bit_count, w_bit_cnt_n;
  logic [NB_COUNT-1:0]   r_error_count, w_err_cnt_n;
  logic                  r_lock, r_ber_zero;
  logic [MAX_LAT-1:0]    r_hist, w_hist_next;

  logic                  w_sym, w_rx_bit, w_prbs_bit, w_err;
  logic                  w_win_last, w_lat_wrap;
  logic [NB_WIN:0]       w_win_sum;
  logic [NB_PHASE-1:0]   w_phase_step, w_phase_hold;
  logic                  w_unused;

  assign w_sym      = i_valid && (r_phase_cnt == r_phase);
  assign w_rx_bit   = i_data[NB_DATA-1];
  assign w_win_last = (r_win_cnt == {NB_WIN{1'b1}});
  assign w_lat_wrap = (r_latency == LAT_MAX);
  assign w_win_sum  = r_win_err + {{NB_WIN{1'b0}}, w_err};
  assign w_unused   = ^{i_data[NB_DATA-2:0], r_hist[MAX_LAT-1]};

`ifdef BER_AUTOPHASE_EN
  assign w_phase_step = w_lat_wrap ? ((r_phase == PHASE_MAX) ? '0 : r_phase + 1'b1) : r_phase;
  assign w_phase_hold = r_phase;
`else
  assign w_phase_step = i_phase;
  assign w_phase_hold = i_phase;
`endif

  ber_checker_prbs9 #(
    .SEED(SEED)
  ) u_prbs9 (
    .clock   (clock),
    .i_reset (~i_reset),
    .i_enable(w_sym),
    .o_bit   (w_prbs_bit)
  );

  // Index 0 is the reference bit emitted on this very symbol.
  always_comb begin
    w_hist_next    = '0;
    w_hist_next[0] = w_prbs_bit;
    for (int i = 1; i < MAX_LAT; i++) begin
      w_hist_next[i] = r_hist[i-1];
    end
  end

  assign w_err = w_rx_bit ^ w_hist_next[r_latency];

  always_comb begin
    w_state_n   = r_state;
    w_lat_n     = r_latency;
    w_phase_n   = r_phase;
    w_win_cnt_n = r_win_cnt;
    w_win_err_n = r_win_err;
    w_bit_cnt_n = r_bit_count;
    w_err_cnt_n = r_error_count;
    if (r_state == ST_IDLE) begin
      w_win_cnt_n = '0;
      w_win_err_n = '0;
      w_phase_n   = i_phase;
    end
    if (!i_enable) begin
      w_state_n = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_n = ST_SEARCH;
        ST_SEARCH: begin
          if (w_sym) begin
            w_win_cnt_n = r_win_cnt + 1'b1;
            w_win_err_n = w_win_sum;
            if (w_win_last) begin
              w_win_err_n = '0;
              if (int'(w_win_sum) <= LOCK_THR) begin
                w_state_n = ST_LOCKED;
              end else begin
                w_lat_n   = w_lat_wrap ? '0 : r_latency + 1'b1;
                w_phase_n = w_phase_step;
              end
            end
          end
        end
        ST_LOCKED: begin
          if (w_sym) begin
            if (!(&r_bit_count)) w_bit_cnt_n = r_bit_count + 1'b1;
            if (w_err && !(&r_error_count)) w_err_cnt_n = r_error_count + 1'b1;
            w_win_cnt_n = r_win_cnt + 1'b1;
            w_win_err_n = w_win_last ? '0 : w_win_sum;
            // Loss of lock restarts the search at the latency we just lost.
            if (int'(w_win_sum) > LOL_THR) begin
              w_state_n   = ST_SEARCH;
              w_win_cnt_n = '0;
              w_win_err_n = '0;
              w_phase_n   = w_phase_hold;
            end
          end
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
    if (i_clear) begin
      w_bit_cnt_n = '0;
      w_err_cnt_n = '0;
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_latency     <= '0;
      r_phase       <= '0;
      r_phase_cnt   <= '0;
      r_win_cnt     <= '0;
      r_win_err     <= '0;
      r_bit_count   <= '0;
      r_error_count <= '0;
      r_lock        <= 1'b0;
      r_ber_zero    <= 1'b1;
      r_hist        <= '0;
    end else begin
      r_state       <= w_state_n;
      r_latency     <= w_lat_n;
      r_phase       <= w_phase_n;
      r_win_cnt     <= w_win_cnt_n;
      r_win_err     <= w_win_err_n;
      r_bit_count   <= w_bit_cnt_n;
      r_error_count <= w_err_cnt_n;
      r_lock        <= (w_state_n == ST_LOCKED);
      r_ber_zero    <= (w_err_cnt_n == '0);
      if (i_valid) begin
        r_phase_cnt <= (r_phase_cnt == PHASE_MAX) ? '0 : r_phase_cnt + 1'b1;
      end
      if (w_sym) begin
        r_hist <= w_hist_next;
      end
    end
  end

  assign o_lock        = r_lock;
  assign o_latency     = r_latency;
  assign o_phase       = r_phase;
  assign o_bit_count   = r_bit_count;
  assign o_error_count = r_error_count;
  assign o_ber_zero    = r_ber_zero;

endmodule

// File: tb/tb_ber_checker.sv
// Directed bench for ber_checker: ideal +/-64 BPSK channel delayed 37 symbols from a PRBS9
// with the checker's seed; a second small instance covers saturation (and autophase).
module tb_ber_checker;

  logic              clock = 1'b0;
  logic              i_reset = 1'b1;
  logic signed [7:0] i_data = '0;
  logic              i_valid = 1'b0;
  logic              i_enable = 1'b0;
  logic [1:0]        i_phase = 2'd2;
  logic              i_clear = 1'b0;

  logic              o_lock, o_ber_zero;
  logic [8:0]        o_latency;
  logic [1:0]        o_phase;
  logic [63:0]       o_bit_count, o_error_count;

  logic              s_lock, s_ber_zero;
  logic [5:0]        s_latency;
  logic [1:0]        s_phase;
  logic [3:0]        s_bit_count, s_error_count;

  int n_tests = 0;
  int n_fail  = 0;

  bit p_seq [511];
  int sym_idx = 0;
  int delay = 37;
  bit phase_mode = 1'b0;

  always #5 clock = ~clock;

  ber_checker u_dut (
    .clock(clock), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .i_enable(i_enable), .i_phase(i_phase), .i_clear(i_clear),
    .o_lock(o_lock), .o_latency(o_latency), .o_phase(o_phase),
    .o_bit_count(o_bit_count), .o_error_count(o_error_count), .o_ber_zero(o_ber_zero)
  );

  ber_checker #(.MAX_LAT(64), .NB_WIN(4), .NB_COUNT(4)) u_dut_sat (
    .clock(clock), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .i_enable(i_enable), .i_phase(i_phase), .i_clear(i_clear),
    .o_lock(s_lock), .o_latency(s_latency), .o_phase(s_phase),
    .o_bit_count(s_bit_count), .o_error_count(s_error_count), .o_ber_zero(s_ber_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One channel symbol = 4 samples; in phase_mode only sample 1 carries the true bit.
  task automatic drive_sym(input bit inv, input bit clr);
    bit b;
    b = p_seq[((sym_idx - delay) % 511 + 511) % 511] ^ inv;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      i_valid = 1'b1;
      i_clear = clr && (k == 2);
      i_data  = (b ^ (phase_mode && (k != 1))) ? -8'sd64 : 8'sd64;
      @(posedge clock);
      #1;
    end
    sym_idx++;
  endtask

  task automatic run_syms(input int n);
    for (int i = 0; i < n; i++) drive_sym(1'b0, 1'b0);
  endtask

  task automatic start_run();
    i_valid = 1'b0;
    repeat (3) @(negedge clock);
    i_enable = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    logic [8:0] sr;
    int guard;
    sr = 9'h1AA;
    for (int i = 0; i < 511; i++) begin
      p_seq[i] = sr[8];
      sr = {sr[7:0], sr[8] ^ sr[4]};
    end

    #1 i_reset = 1'b0;
    #1;
    chk("rst_lock", o_lock, 0);
    chk("rst_bits", o_bit_count, 0);
    chk("rst_errs", o_error_count, 0);
    chk("rst_lat", o_latency, 0);
    chk("rst_berzero", o_ber_zero, 1);
    chk("rst_phase", o_phase, 0);
    repeat (2) @(negedge clock);
    i_reset = 1'b1;

    start_run();
    run_syms(2431);
    chk("prelock_lock", o_lock, 0);
    run_syms(1);
    chk("lock_rise", o_lock, 1);
    chk("lock_lat", o_latency, 37);
    chk("lock_phase", o_phase, 2);
    chk("lock_bits", o_bit_count, 0);
    chk("sat_lock", s_lock, 1);
    chk("sat_lat", s_latency, 37);
    chk("sat_bits", s_bit_count, 15);

    run_syms(500);
    chk("bits_500", o_bit_count, 500);
    chk("errs_500", o_error_count, 0);
    drive_sym(1'b0, 1'b1);
    chk("clr_bits", o_bit_count, 0);
    chk("clr_lock", o_lock, 1);
    chk("clr_lat", o_latency, 37);
    chk("sat_clr_bits", s_bit_count, 0);

    i_phase = 2'd0;
    for (int blk = 0; blk < 10; blk++) begin
      for (int j = 0; j < 100; j++) drive_sym(j == 50, 1'b0);
    end
    chk("inj_bits", o_bit_count, 1000);
    chk("inj_errs", o_error_count, 10);
    chk("inj_berzero", o_ber_zero, 0);
    chk("inj_lock", o_lock, 1);
    chk("inj_phase_held", o_phase, 2);
    chk("sat_bits_stick", s_bit_count, 15);
    i_phase = 2'd2;

    for (int j = 0; j < 8; j++) drive_sym(1'b1, 1'b0);
    chk("burst8_lock", o_lock, 1);
    chk("burst8_errs", o_error_count, 18);
    drive_sym(1'b1, 1'b0);
    chk("lol_lock", o_lock, 0);
    chk("lol_bits", o_bit_count, 1009);
    chk("lol_errs", o_error_count, 19);
    chk("sat_errs_stick", s_error_count, 15);

    run_syms(32);
    chk("search_bits_frozen", o_bit_count, 1009);
    chk("search_lat_held", o_latency, 37);
    run_syms(31);
    chk("prerelock_lock", o_lock, 0);
    run_syms(1);
    chk("relock", o_lock, 1);
    chk("relock_lat", o_latency, 37);

    @(negedge clock);
    i_enable = 1'b0;
    i_valid  = 1'b0;
    @(posedge clock);
    #1;
    chk("dis_lock", o_lock, 0);
    chk("dis_bits", o_bit_count, 1009);
    chk("dis_errs", o_error_count, 19);

    #2 i_reset = 1'b0;
    #1;
    chk("arst_bits", o_bit_count, 0);
    chk("arst_errs", o_error_count, 0);
    chk("arst_lat", o_latency, 0);
    chk("arst_berzero", o_ber_zero, 1);
    chk("arst_phase", o_phase, 0);

`ifdef BER_AUTOPHASE_EN
    @(negedge clock);
    i_reset    = 1'b1;
    sym_idx    = 0;
    phase_mode = 1'b1;
    i_phase    = 2'd3;
    start_run();
    guard = 0;
    while (s_phase == 2'd3 && guard < 3000) begin
      drive_sym(1'b0, 1'b0);
      guard++;
    end
    chk("ap_phase_step", s_phase, 0);
    chk("ap_nolock", s_lock, 0);
    while (!s_lock && guard < 6000) begin
      drive_sym(1'b0, 1'b0);
      guard++;
    end
    chk("ap_lock", s_lock, 1);
    chk("ap_lock_phase", s_phase, 1);
    chk("ap_lock_lat", s_latency, 38);
`else
    guard = 0;
    sr = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
